// File: rtl/checkpoint_ctrl_pkg.sv
// Shared definitions for the branch checkpoint scheduler.
//   CP_INDEX_SIZE : width of a checkpoint slot index
//   CP_NUM        : number of checkpoint slots (2**CP_INDEX_SIZE)
//   cp_idx_t      : slot index type
//   cp_state_t    : recovery sequencer states
package checkpoint_ctrl_pkg;

    localparam int unsigned CP_INDEX_SIZE = 2;
    localparam int unsigned CP_NUM        = 1 << CP_INDEX_SIZE;

    typedef logic [CP_INDEX_SIZE-1:0] cp_idx_t;

    typedef enum logic [1:0] {
        IDLE,
        RECOVER,
        DRAIN
    } cp_state_t;

endpackage

// File: rtl/cp_squash_mask.sv
// Squash mask for a mispredicted branch checkpoint.
// Marks resolve_idx and every slot younger than it, i.e. slots
// resolve_idx .. tail-1 in circular age order.
//   resolve_idx : checkpoint of the mispredicted branch
//   tail        : next slot to allocate
//   squash_mask : CP_NUM-bit mask of slots to clear
module cp_squash_mask
    import checkpoint_ctrl_pkg::*;
(
    input  cp_idx_t            resolve_idx,
    input  cp_idx_t            tail,
    output logic [CP_NUM-1:0]  squash_mask
);

    cp_idx_t span;
    cp_idx_t offset;

    always_comb begin
        span        = tail - resolve_idx;
        offset      = '0;
        squash_mask = '0;
        for (int unsigned i = 0; i < CP_NUM; i++) begin
            offset = cp_idx_t'(i) - resolve_idx;
            // span==0 with a live resolve_idx can only mean the ring is full:
            // everything from resolve_idx around to tail-1 goes.
            squash_mask[i] = (span == '0) || (offset < span);
        end
    end

endmodule

// File: rtl/checkpoint_ctrl.sv
// Checkpoint scheduler for the rename stage.
// Allocates branch checkpoint slots in ring order at the tail, frees them on
// branch resolution and sequences recovery (recover pulse + drain stall) on
// a mispredict.
//   clock, reset            : clock, asynchronous active-high reset
//   alloc_req/gnt/idx       : checkpoint allocation handshake (combinational)
//   stall                   : rename must hold
//   check/check_idx         : snapshot strobe to freelist/RAT
//   resolve_valid/idx/mispred : branch resolution from the branch unit
//   recover/recover_idx     : registered restore pulse to freelist/RAT
//   cp_valid                : live-slot mask
module checkpoint_ctrl
    import checkpoint_ctrl_pkg::*;
#(
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output cp_idx_t           alloc_idx,
    output logic              stall,
    output logic              check,
    output cp_idx_t           check_idx,
    input  logic              resolve_valid,
    input  cp_idx_t           resolve_idx,
    input  logic              resolve_mispred,
    output logic              recover,
    output cp_idx_t           recover_idx,
    output logic [CP_NUM-1:0] cp_valid
);

    cp_state_t           state_q, state_d;
    logic [CP_NUM-1:0]   valid_q, valid_d;
    cp_idx_t             tail_q, tail_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                recover_q, recover_d;
    cp_idx_t             recover_idx_q, recover_idx_d;

    logic                full;
    logic                resolve_live;
    logic                mispred_hit;
    logic                correct_hit;
    logic [CP_NUM-1:0]   squash_mask;

    cp_squash_mask u_squash (
        .resolve_idx (resolve_idx),
        .tail        (tail_q),
        .squash_mask (squash_mask)
    );

    always_comb begin
        full         = valid_q[tail_q];
        resolve_live = resolve_valid & valid_q[resolve_idx];
        mispred_hit  = resolve_live & resolve_mispred;
        correct_hit  = resolve_live & ~resolve_mispred;

        // Mispredict wins over a same-cycle allocation.
        alloc_gnt = alloc_req & ~full & (state_q == IDLE) & ~mispred_hit;
        alloc_idx = tail_q;
        check     = alloc_gnt;
        check_idx = tail_q;
        stall     = full | (state_q != IDLE) | mispred_hit;

        recover     = recover_q;
        recover_idx = recover_idx_q;
        cp_valid    = valid_q;
    end

    // Slot bookkeeping. A grant and a correct resolve can never target the
    // same slot: the grant needs valid[tail]=0, the resolve needs it live.
    always_comb begin
        valid_d = valid_q;
        tail_d  = tail_q;
        if (alloc_gnt) begin
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + cp_idx_t'(1);
        end
        if (correct_hit) begin
            valid_d[resolve_idx] = 1'b0;
        end
        if (mispred_hit) begin
            valid_d = valid_q & ~squash_mask;
            tail_d  = resolve_idx;
        end
    end

    // Recovery sequencer.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        recover_d     = 1'b0;
        recover_idx_d = recover_idx_q;
        if (mispred_hit) begin
            // Restarts the whole sequence even mid-recovery.
            state_d       = RECOVER;
            recover_d     = 1'b1;
            recover_idx_d = resolve_idx;
        end else begin
            unique case (state_q)
                IDLE: ;
                RECOVER: begin
                    state_d = DRAIN;
                    cnt_d   = 4'(RECOVER_CYCLES - 1);
                end
                DRAIN: begin
                    if (cnt_q == 4'd0) begin
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            valid_q       <= '0;
            tail_q        <= '0;
            cnt_q         <= '0;
            recover_q     <= 1'b0;
            recover_idx_q <= '0;
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            tail_q        <= tail_d;
            cnt_q         <= cnt_d;
            recover_q     <= recover_d;
            recover_idx_q <= recover_idx_d;
        end
    end

endmodule

// File: tb/tb_checkpoint_ctrl.sv
// Self-checking bench for checkpoint_ctrl: directed scenarios plus a random
// run, all checked against a ring-of-slots reference model.
module tb_checkpoint_ctrl;

    localparam int RC = 2;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       alloc_req = 1'b0;
    logic       alloc_gnt;
    logic [1:0] alloc_idx;
    logic       stall;
    logic       check;
    logic [1:0] check_idx;
    logic       resolve_valid = 1'b0;
    logic [1:0] resolve_idx = 2'd0;
    logic       resolve_mispred = 1'b0;
    logic       recover;
    logic [1:0] recover_idx;
    logic [3:0] cp_valid;

    always #5 clock = ~clock;

    checkpoint_ctrl #(.RECOVER_CYCLES(RC)) dut (
        .clock           (clock),
        .reset           (reset),
        .alloc_req       (alloc_req),
        .alloc_gnt       (alloc_gnt),
        .alloc_idx       (alloc_idx),
        .stall           (stall),
        .check           (check),
        .check_idx       (check_idx),
        .resolve_valid   (resolve_valid),
        .resolve_idx     (resolve_idx),
        .resolve_mispred (resolve_mispred),
        .recover         (recover),
        .recover_idx     (recover_idx),
        .cp_valid        (cp_valid)
    );

    int total = 0;
    int bad   = 0;

    // Reference model: live bits, tail, remaining non-idle cycles.
    bit [3:0] m_valid;
    int       m_tail;
    int       m_busy;
    bit       m_rec;
    int       m_rec_idx;
    bit       e_gnt;
    bit       e_stall;

    task automatic model_reset();
        m_valid = '0; m_tail = 0; m_busy = 0; m_rec = 0; m_rec_idx = 0;
    endtask

    task automatic model_comb();
        bit mis;
        mis     = resolve_valid && resolve_mispred && m_valid[resolve_idx];
        e_gnt   = alloc_req && !m_valid[m_tail] && (m_busy == 0) && !mis;
        e_stall = m_valid[m_tail] || (m_busy > 0) || mis;
    endtask

    task automatic drive(input bit req, input bit rv, input bit rm, input int ridx);
        @(negedge clock);
        alloc_req = req; resolve_valid = rv; resolve_mispred = rm;
        resolve_idx = 2'(ridx);
        #1;
        model_comb();
    endtask

    // Commit the model for the current inputs, then pass the clock edge.
    task automatic advance();
        int r, j;
        bit hit, mis, cor;
        bit [3:0] nv;
        r   = int'(resolve_idx);
        hit = resolve_valid && m_valid[r];
        mis = hit && resolve_mispred;
        cor = hit && !resolve_mispred;
        nv  = m_valid;
        if (e_gnt) nv[m_tail] = 1'b1;
        if (cor) nv[r] = 1'b0;
        if (mis) begin
            // Walk from the mispredicted branch to the youngest live slot.
            j = r;
            do begin
                nv[j] = 1'b0;
                j = (j + 1) % 4;
            end while (j != m_tail);
            m_tail = r;
        end else if (e_gnt) begin
            m_tail = (m_tail + 1) % 4;
        end
        m_valid = nv;
        m_rec   = mis;
        if (mis) m_rec_idx = r;
        m_busy  = mis ? 1 + RC : (m_busy > 0 ? m_busy - 1 : 0);
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        alloc_req = 0; resolve_valid = 0; resolve_mispred = 0; resolve_idx = 0;
        model_reset();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic alloc_n(input int n);
        for (int k = 0; k < n; k++) begin
            drive(1, 0, 0, 0);
            advance();
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%b exp=0", alloc_gnt); end
        total++; if (check !== 1'b0) begin bad++; $display("FAIL reset_check got=%b exp=0", check); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (alloc_idx !== 2'd0 || check_idx !== 2'd0) begin
            bad++; $display("FAIL reset_idx got=%0d/%0d exp=0/0", alloc_idx, check_idx); end
        total++; if (recover !== 1'b0 || recover_idx !== 2'd0) begin
            bad++; $display("FAIL reset_recover got=%b/%0d exp=0/0", recover, recover_idx); end
        total++; if (cp_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", cp_valid); end
    endtask

    task automatic test_fill();
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, 0, 0);
            total++; if (alloc_gnt !== (k < 4) || alloc_gnt !== e_gnt) begin
                bad++; $display("FAIL fill_gnt k=%0d got=%b exp=%b", k, alloc_gnt, k < 4); end
            total++; if (check !== (k < 4) || check_idx !== 2'(k)) begin
                bad++; $display("FAIL fill_check k=%0d got=%b/%0d exp=%b/%0d", k, check, check_idx, k < 4, k % 4); end
            if (k < 4) begin
                total++; if (alloc_idx !== 2'(k)) begin
                    bad++; $display("FAIL fill_idx got=%0d exp=%0d", alloc_idx, k); end
            end else begin
                total++; if (stall !== 1'b1 || cp_valid !== 4'b1111) begin
                    bad++; $display("FAIL fill_full got=%b/%b exp=1/1111", stall, cp_valid); end
            end
            advance();
        end
    endtask

    // Continues from the full ring left by test_fill.
    task automatic test_correct_resolve();
        drive(1, 1, 0, 0);
        total++; if (alloc_gnt !== 1'b0) begin bad++; $display("FAIL cres_same_cycle_gnt got=%b exp=0", alloc_gnt); end
        advance();
        drive(1, 0, 0, 0);
        total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'd0) begin
            bad++; $display("FAIL cres_regrant got=%b/%0d exp=1/0", alloc_gnt, alloc_idx); end
        advance();
        drive(1, 0, 0, 0);
        total++; if (cp_valid !== 4'b1111 || alloc_idx !== 2'd1 || alloc_gnt !== 1'b0) begin
            bad++; $display("FAIL cres_after got=%b/%0d/%b exp=1111/1/0", cp_valid, alloc_idx, alloc_gnt); end
        advance();
    endtask

    task automatic test_mispredict();
        int n;
        bit s;
        do_reset();
        alloc_n(3);
        drive(0, 1, 1, 1);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mis_hit_stall got=%b exp=1", stall); end
        advance();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0);
            if (k == 0) begin
                total++; if (recover !== 1'b1 || recover_idx !== 2'd1 || cp_valid !== 4'b0001) begin
                    bad++; $display("FAIL mis_recover got=%b/%0d/%b exp=1/1/0001", recover, recover_idx, cp_valid); end
            end else begin
                total++; if (recover !== 1'b0) begin bad++; $display("FAIL mis_pulse_len k=%0d got=%b exp=0", k, recover); end
            end
            s = stall;
            advance();
            if (!s) break;
            n++;
        end
        total++; if (n != 1 + RC) begin bad++; $display("FAIL mis_stall_cycles got=%0d exp=%0d", n, 1 + RC); end
        drive(1, 0, 0, 0);
        total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'd1) begin
            bad++; $display("FAIL mis_next_grant got=%b/%0d exp=1/1", alloc_gnt, alloc_idx); end
        advance();
    endtask

    task automatic test_alloc_vs_mispred();
        do_reset();
        alloc_n(3);
        drive(1, 1, 1, 2);
        total++; if (alloc_gnt !== 1'b0 || check !== 1'b0) begin
            bad++; $display("FAIL avm_gnt got=%b/%b exp=0/0", alloc_gnt, check); end
        advance();
        drive(0, 0, 0, 0);
        total++; if (recover !== 1'b1 || recover_idx !== 2'd2 || cp_valid !== 4'b0011) begin
            bad++; $display("FAIL avm_recover got=%b/%0d/%b exp=1/2/0011", recover, recover_idx, cp_valid); end
        advance();
        for (int k = 0; k < RC; k++) begin drive(0, 0, 0, 0); advance(); end
    endtask

    task automatic test_nonlive();
        do_reset();
        alloc_n(3);
        drive(0, 1, 0, 3);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL nl_correct_stall got=%b exp=0", stall); end
        advance();
        drive(0, 1, 1, 3);
        total++; if (stall !== 1'b0 || cp_valid !== 4'b0111) begin
            bad++; $display("FAIL nl_mis got=%b/%b exp=0/0111", stall, cp_valid); end
        advance();
        drive(0, 0, 0, 0);
        total++; if (recover !== 1'b0 || cp_valid !== 4'b0111 || alloc_idx !== 2'd3) begin
            bad++; $display("FAIL nl_after got=%b/%b/%0d exp=0/0111/3", recover, cp_valid, alloc_idx); end
        advance();
    endtask

    task automatic test_nested_recover();
        int n;
        bit s;
        do_reset();
        alloc_n(3);
        drive(0, 1, 1, 2); advance();  // mispredict idx 2
        drive(0, 0, 0, 0); advance();  // recover cycle
        drive(0, 1, 1, 0);             // in DRAIN, older live branch
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL nest_stall got=%b exp=1", stall); end
        advance();
        n = 0;
        for (int k = 0; k < 10; k++) begin
            drive(0, 0, 0, 0);
            if (k == 0) begin
                total++; if (recover !== 1'b1 || recover_idx !== 2'd0 || cp_valid !== 4'b0000 || alloc_idx !== 2'd0) begin
                    bad++; $display("FAIL nest_recover got=%b/%0d/%b/%0d exp=1/0/0000/0",
                                    recover, recover_idx, cp_valid, alloc_idx); end
            end
            s = stall;
            advance();
            if (!s) break;
            n++;
        end
        total++; if (n != 1 + RC) begin bad++; $display("FAIL nest_stall_cycles got=%0d exp=%0d", n, 1 + RC); end
    endtask

    task automatic test_reset_mid_recovery();
        do_reset();
        alloc_n(2);
        drive(0, 1, 1, 0);
        advance();
        #2;
        total++; if (recover !== m_rec) begin bad++; $display("FAIL rmid_pre got=%b exp=%b", recover, m_rec); end
        reset = 1'b1;
        #1;
        total++; if (recover !== 1'b0 || recover_idx !== 2'd0 || cp_valid !== 4'b0000 || stall !== 1'b0) begin
            bad++; $display("FAIL rmid_abort got=%b/%0d/%b/%b exp=0/0/0000/0", recover, recover_idx, cp_valid, stall); end
        model_reset();
        @(negedge clock);
        reset = 1'b0;
        drive(1, 0, 0, 0);
        total++; if (alloc_gnt !== 1'b1 || alloc_idx !== 2'd0) begin
            bad++; $display("FAIL rmid_grant got=%b/%0d exp=1/0", alloc_gnt, alloc_idx); end
        advance();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
                  $urandom_range(0, 5) == 0, int'($urandom_range(0, 3)));
            total++; if (alloc_gnt !== e_gnt || check !== e_gnt) begin
                bad++; $display("FAIL rnd_gnt c=%0d got=%b/%b exp=%b", c, alloc_gnt, check, e_gnt); end
            total++; if (alloc_idx !== 2'(m_tail) || check_idx !== 2'(m_tail)) begin
                bad++; $display("FAIL rnd_idx c=%0d got=%0d/%0d exp=%0d", c, alloc_idx, check_idx, m_tail); end
            total++; if (stall !== e_stall) begin
                bad++; $display("FAIL rnd_stall c=%0d got=%b exp=%b", c, stall, e_stall); end
            total++; if (recover !== m_rec || recover_idx !== 2'(m_rec_idx)) begin
                bad++; $display("FAIL rnd_recover c=%0d got=%b/%0d exp=%b/%0d", c, recover, recover_idx, m_rec, m_rec_idx); end
            total++; if (cp_valid !== m_valid) begin
                bad++; $display("FAIL rnd_valid c=%0d got=%b exp=%b", c, cp_valid, m_valid); end
            advance();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill();
        test_correct_resolve();
        test_mispredict();
        test_alloc_vs_mispred();
        test_nonlive();
        test_nested_recover();
        test_reset_mid_recovery();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
